ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite memory endpoint and single-master grant generator that sits directly downstream of the AXI-to-AHB bridge. It consumes the bridge's AHB master outputs (`hbusreq`, `haddr`, `htrans`, `hwrite`, `hsize`, `hburst`, `hwdata`) and returns `hgrant`, `hready`, `hresp` and `hrdata`. Storage is a word-addressed, byte-lane-writable register array. It gives the bridge a closed bus for system simulation and FPGA bring-up.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: number of 32-bit words is 2^DEPTH_LOG2, so 4 KB by default.
- `BASE_ADDR`, default 32'h0000_0000: region base; must be aligned to the region size.
- `WAIT_CYCLES`, default 1, legal range 1..15: wait states per OKAY data phase; used only when `AHB_SRAM_WAIT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ahb_hbusreq`  in  1  bus request from the bridge.
- `ahb_hgrant`  out  1  bus grant.
- `ahb_haddr`  in  32  address.
- `ahb_htrans`  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `ahb_hwrite`  in  1  1 = write.
- `ahb_hsize`  in  3  transfer size: 0 = byte, 1 = halfword, 2 = word.
- `ahb_hburst`  in  3  burst type; accepted and otherwise ignored.
- `ahb_hwdata`  in  32  write data, valid in the data phase.
- `ahb_hrdata`  out  32  read data.
- `ahb_hready`  out  1  transfer done / bus ready.
- `ahb_hresp`  out  2  OKAY=00, ERROR=01.

## Operation
- Grant register:
  - Reset value 0.
  - Set on the edge where `hbusreq`=1.
  - Cleared on an edge where `hbusreq`=0, `hready`=1 and `htrans`=IDLE.
  - Never changes while `hready`=0.
- Address-phase sample:
  - Taken on an edge where `hready`=1 and `htrans` is NONSEQ or SEQ.
  - Latches `haddr`, `hwrite` and `hsize`.
  - IDLE or BUSY when `hready`=1 starts no data phase; the response stays OKAY with zero wait.
- Error check, evaluated at sample time. The transfer is an error if any of these holds:
  - `haddr[31:DEPTH_LOG2+2]` differs from `BASE_ADDR[31:DEPTH_LOG2+2]`;
  - `hsize` > 2;
  - `hsize`=1 and `haddr[0]`=1;
  - `hsize`=2 and `haddr[1:0]`≠0.
- States:
  - IDLE: `hready`=1, `hresp`=OKAY.
  - WAIT: `hready`=0, `hresp`=OKAY; counts down WAIT_CYCLES.
  - LAST: `hready`=1, `hresp`=OKAY; the final data-phase cycle.
  - ERR1: `hready`=0, `hresp`=ERROR.
  - ERR2: `hready`=1, `hresp`=ERROR.
- Transitions:
  - From IDLE or LAST, a sampled OKAY transfer goes to WAIT if the macro is defined, otherwise to LAST.
  - From IDLE or LAST, a sampled error transfer goes to ERR1.
  - From IDLE or LAST with no sampled transfer, go to IDLE.
  - WAIT goes to LAST when the counter reaches 0.
  - ERR1 always goes to ERR2.
  - ERR2 behaves like IDLE for sampling the next address phase. An address presented during ERR2 is sampled, because `hready`=1.
- Write commit:
  - Happens on the edge that ends LAST with the latched write flag set.
  - Lanes are little-endian:
    - byte: lane `addr[1:0]`;
    - halfword: lanes {`addr[1]`,0} and {`addr[1]`,1};
    - word: all four lanes.
  - Error transfers never write.
- Read data:
  - `hrdata` = mem[latched word index] combinationally while the state is LAST and the latched write flag is 0.
  - `hrdata` = 0 in all other states.
  - A read whose data phase directly follows a write to the same word returns the newly written data, because the write commits at the edge ending that write's data phase.
- Memory contents are not reset.

## Timing
- Reset values: `ahb_hgrant`=0, `ahb_hready`=1, `ahb_hresp`=00, `ahb_hrdata`=0, state=IDLE, wait counter=0.
- Reset asserted mid-transfer aborts immediately with no write; the transfer is lost.
- Zero-wait transfer (macro off): address sampled at edge N; data phase is cycle N+1 with `hready`=1; a write commits at edge N+1.
- With the macro on: the data phase spans WAIT_CYCLES+1 cycles; `hready`=0 for the first WAIT_CYCLES.
- Error response: exactly 2 cycles, ERR1 then ERR2, regardless of the macro.
- Back-to-back pipelined NONSEQ/SEQ transfers run at one transfer per cycle when the macro is off.
- Grant latency: 1 cycle from `hbusreq` rising.

## Configuration
- `AHB_SRAM_WAIT_EN` defined: the WAIT state and its 4-bit down-counter are compiled in; every OKAY data phase inserts WAIT_CYCLES wait states.
- `AHB_SRAM_WAIT_EN` undefined: no WAIT state and no counter; `hready` is 0 only in ERR1; the `WAIT_CYCLES` parameter is ignored.

## Test plan
- Word write then read, macro off: write 32'hDEAD_BEEF to 0x10, then read 0x10 back-to-back → `hrdata`=32'hDEAD_BEEF in the read's data phase; `hready`=1 throughout.
- Byte lanes: word write 0 to 0x20, then byte writes 0x11 to 0x21 and 0x22 to 0x23, then a word read at 0x20 → `hrdata`=32'h2200_1100.
- Errors:
  - Word access to 0x02 → `hready` 0 then 1 with `hresp`=01 for 2 cycles, and memory is unchanged.
  - Access to 0x0000_1000 (out of range) → same 2-cycle ERROR.
- Wait states: macro on with WAIT_CYCLES=3, read at 0x10 → `hready` low for 3 cycles, then high with valid data.
- Grant: `hbusreq` high at edge N → `hgrant`=1 after edge N. Drop `hbusreq` while a wait state holds `hready`=0 → `hgrant` stays 1 until `hready`=1 and `htrans`=IDLE.
- Reset mid-write: assert `rst` during WAIT of a write to 0x30 → outputs return to reset values asynchronously, and word 0x30 is not modified.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM endpoint with single-master grant generator
// Define AHB_SRAM_WAIT_EN to insert WAIT_CYCLES wait states into every OKAY data phase.
module ahb_sram_slave #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ahb_hbusreq,
  output logic        ahb_hgrant,
  input  logic [31:0] ahb_haddr,
  input  logic [1:0]  ahb_htrans,
  input  logic        ahb_hwrite,
  input  logic [2:0]  ahb_hsize,
  input  logic [2:0]  ahb_hburst,
  input  logic [31:0] ahb_hwdata,
  output logic [31:0] ahb_hrdata,
  output logic        ahb_hready,
  output logic [1:0]  ahb_hresp
);
  localparam int unsigned AW = DEPTH_LOG2 + 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LAST = 3'd1,
    S_ERR1 = 3'd2,
    S_ERR2 = 3'd3
`ifdef AHB_SRAM_WAIT_EN
    , S_WAIT = 3'd4
`endif
  } state_t;

  state_t                state_q, state_d;
  logic                  hready_q, hready_d;
  logic [1:0]            hresp_q, hresp_d;
  logic                  grant_q, grant_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [1:0]            lane_q, lane_d;
  logic [1:0]            size_q, size_d;
  logic                  write_q, write_d;
`ifdef AHB_SRAM_WAIT_EN
  logic [3:0]            cnt_q, cnt_d;
`endif

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic        sample;
  logic        bad;
  logic [3:0]  be;
  logic        unused_ok;

  assign unused_ok = ^{ahb_hburst, 4'(WAIT_CYCLES)};

  always_comb begin
    sample = hready_q && ahb_htrans[1];
    bad = (ahb_haddr[31:AW] != BASE_ADDR[31:AW]) ||
          (ahb_hsize > 3'd2) ||
          ((ahb_hsize == 3'd1) && ahb_haddr[0]) ||
          ((ahb_hsize == 3'd2) && (ahb_haddr[1:0] != 2'b00));

    state_d = state_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    write_d = write_q;
`ifdef AHB_SRAM_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_ERR1: state_d = S_ERR2;
`ifdef AHB_SRAM_WAIT_EN
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_LAST;
        else               cnt_d   = cnt_q - 4'd1;
      end
`endif
      default: begin
        // IDLE, LAST and ERR2 all present hready=1, so each may take a new address phase.
        state_d = S_IDLE;
        if (sample) begin
          idx_d   = ahb_haddr[AW-1:2];
          lane_d  = ahb_haddr[1:0];
          size_d  = ahb_hsize[1:0];
          write_d = ahb_hwrite;
          if (bad) begin
            state_d = S_ERR1;
          end else begin
`ifdef AHB_SRAM_WAIT_EN
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
`else
            state_d = S_LAST;
`endif
          end
        end
      end
    endcase

    hready_d = (state_d != S_ERR1)
`ifdef AHB_SRAM_WAIT_EN
               && (state_d != S_WAIT)
`endif
               ;
    hresp_d = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? 2'b01 : 2'b00;

    grant_d = grant_q;
    if (hready_q) begin
      if (ahb_hbusreq)                grant_d = 1'b1;
      else if (ahb_htrans == 2'b00)   grant_d = 1'b0;
    end

    case (size_q)
      2'd0:    be = 4'b0001 << lane_q;
      2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= 2'b00;
      grant_q  <= 1'b0;
      idx_q    <= '0;
      lane_q   <= 2'b00;
      size_q   <= 2'b00;
      write_q  <= 1'b0;
`ifdef AHB_SRAM_WAIT_EN
      cnt_q    <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      lane_q   <= lane_d;
      size_q   <= size_d;
      write_q  <= write_d;
`ifdef AHB_SRAM_WAIT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Write data is only valid in the final data-phase cycle, so commit on the edge leaving LAST.
  always_ff @(posedge clk) begin
    if ((state_q == S_LAST) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= ahb_hwdata[8*i +: 8];
      end
    end
  end

  assign ahb_hrdata = ((state_q == S_LAST) && !write_q) ? mem[idx_q] : 32'h0;
  assign ahb_hready = hready_q;
  assign ahb_hresp  = hresp_q;
  assign ahb_hgrant = grant_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - randomized scoreboard bench for ahb_sram_slave
module tb_ahb_sram_slave;
  localparam int WAITS = 3;
`ifdef AHB_SRAM_WAIT_EN
  localparam int EXP_WAIT = WAITS;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        hbusreq, hgrant, hwrite, hready;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize, hburst;

  ahb_sram_slave #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(WAITS)) dut (
    .clk(clk), .rst(rst),
    .ahb_hbusreq(hbusreq), .ahb_hgrant(hgrant),
    .ahb_haddr(haddr), .ahb_htrans(htrans), .ahb_hwrite(hwrite),
    .ahb_hsize(hsize), .ahb_hburst(hburst), .ahb_hwdata(hwdata),
    .ahb_hrdata(hrdata), .ahb_hready(hready), .ahb_hresp(hresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] mdl [0:4095];
  bit         dp;
  int         lowcnt;
  bit         badresp;

  function automatic bit model_err(input logic [31:0] a, input logic [2:0] sz);
    if (a >= 32'd4096) return 1'b1;
    if (sz > 3'd2) return 1'b1;
    return (a % (32'd1 << sz)) != 32'd0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int n = 1 << sz;
    for (int i = 0; i < n; i++) mdl[a + i] = wd[8*((a + i) % 4) +: 8];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w = a & ~32'd3;
    return {mdl[w + 3], mdl[w + 2], mdl[w + 1], mdl[w]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    forever begin
      @(negedge clk);
      if (hready) break;
      n++;
      if (n > 40) begin
        tests++;
        fails++;
        $display("FAIL ready_timeout hready=0 for %0d cycles, required 1", n);
        break;
      end
    end
  endtask

  // One address-phase slot; called with inputs aligned just after a rising edge.
  task automatic slot(input logic [1:0] tr, input logic [31:0] a, input bit w,
                      input logic [2:0] sz, input logic [31:0] wd);
    exp_t e;
    htrans = tr; haddr = a; hwrite = w; hsize = sz; hburst = 3'($urandom);
    wait_ready();
    @(posedge clk); #1;
    hwdata = w ? wd : $urandom;
    if (tr[1]) begin
      e.addr = a;
      e.rd   = !w;
      e.err  = model_err(a, sz);
      e.data = 32'h0;
      if (!e.err) begin
        if (w) model_write(a, sz, wd);
        else   e.data = model_read(a);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic check_done();
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_done data phase completed, none outstanding");
    end else begin
      e = exp_q.pop_front();
      tests++;
      if (hresp !== (e.err ? 2'b01 : 2'b00) || badresp) begin
        fails++;
        $display("FAIL resp addr=%h actual=%b required=%b (bad during wait=%0d)",
                 e.addr, hresp, e.err ? 2'b01 : 2'b00, badresp);
      end
      tests++;
      if (lowcnt != (e.err ? 1 : EXP_WAIT)) begin
        fails++;
        $display("FAIL waits addr=%h actual=%0d required=%0d", e.addr, lowcnt, e.err ? 1 : EXP_WAIT);
      end
      if (!e.err && e.rd) begin
        tests++;
        if (hrdata !== e.data) begin
          fails++;
          $display("FAIL rdata addr=%h actual=%h required=%h", e.addr, hrdata, e.data);
        end
      end
    end
  endtask

  initial begin : monitor
    dp = 1'b0; lowcnt = 0; badresp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dp = 1'b0; lowcnt = 0; badresp = 1'b0;
      end else if (!hready) begin
        if (!dp) begin
          tests++;
          fails++;
          $display("FAIL stray_wait hready=0 with no data phase, required 1");
        end else begin
          lowcnt++;
          if (exp_q.size() > 0 && hresp !== (exp_q[0].err ? 2'b01 : 2'b00)) badresp = 1'b1;
        end
      end else begin
        if (dp) check_done();
        else    chk("idle_resp", 32'(hresp), 32'h0);
        dp = htrans[1];
        lowcnt = 0;
        badresp = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          k;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [7:0]  save [0:3];
    htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0;
    hwdata = 32'h0; hbusreq = 1'b0; rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_grant", 32'(hgrant), 32'h0);
    chk("reset_ready", 32'(hready), 32'h1);
    chk("reset_resp", 32'(hresp), 32'h0);
    chk("reset_rdata", hrdata, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    hbusreq = 1'b1;
    @(negedge clk);
    chk("grant_before_edge", 32'(hgrant), 32'h0);
    @(negedge clk);
    chk("grant_after_edge", 32'(hgrant), 32'h1);
    @(posedge clk); #1;

    for (int w = 0; w < 64; w++) slot(2'b10, 32'(w * 4), 1'b1, 3'd2, $urandom);

    slot(2'b10, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF);
    slot(2'b10, 32'h10, 1'b0, 3'd2, 32'h0);
    slot(2'b10, 32'h20, 1'b1, 3'd2, 32'h0);
    slot(2'b10, 32'h21, 1'b1, 3'd0, 32'h0000_1100);
    slot(2'b10, 32'h23, 1'b1, 3'd0, 32'h2200_0000);
    slot(2'b10, 32'h20, 1'b0, 3'd2, 32'h0);
    slot(2'b10, 32'h02, 1'b1, 3'd2, 32'hFFFF_FFFF);
    slot(2'b10, 32'h1000, 1'b1, 3'd2, 32'hFFFF_FFFF);
    slot(2'b10, 32'h00, 1'b0, 3'd2, 32'h0);
    slot(2'b10, 32'h01, 1'b1, 3'd1, 32'hFFFF_FFFF);
    slot(2'b10, 32'h04, 1'b1, 3'd3, 32'hFFFF_FFFF);
    slot(2'b10, 32'h04, 1'b0, 3'd2, 32'h0);

    // Drop the request while ERR1 holds hready low: grant must survive until hready returns.
    slot(2'b10, 32'h02, 1'b0, 3'd2, 32'h0);
    htrans = 2'b00; hbusreq = 1'b0;
    @(negedge clk);
    chk("grant_err1", 32'(hgrant), 32'h1);
    @(negedge clk);
    chk("grant_held_low_ready", 32'(hgrant), 32'h1);
    @(negedge clk);
    chk("grant_released", 32'(hgrant), 32'h0);
    hbusreq = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) save[i] = mdl[32'h30 + i];
    slot(2'b10, 32'h30, 1'b1, 3'd2, 32'hA5A5_5A5A);
    htrans = 2'b00;
    rst = 1'b1;
    #1;
    chk("async_rst_grant", 32'(hgrant), 32'h0);
    chk("async_rst_ready", 32'(hready), 32'h1);
    chk("async_rst_resp", 32'(hresp), 32'h0);
    chk("async_rst_rdata", hrdata, 32'h0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) mdl[32'h30 + i] = save[i];
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    slot(2'b00, 32'h0, 1'b0, 3'd2, 32'h0);
    slot(2'b10, 32'h30, 1'b0, 3'd2, 32'h0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0)
        slot($urandom_range(0, 1) ? 2'b01 : 2'b00, $urandom, 1'($urandom), 3'($urandom), $urandom);
      k  = $urandom_range(0, 99);
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      if (k < 80)      a = a & ~((32'd1 << sz) - 32'd1);
      else if (k < 90) a = a;
      else if (k < 95) a = $urandom | 32'h0000_1000;
      else             sz = 3'($urandom_range(3, 7));
      slot($urandom_range(0, 1) ? 2'b11 : 2'b10, a, 1'($urandom), sz, $urandom);
    end

    slot(2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
    slot(2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
